spk_layer_engine: RTL and testbench
===================================

// Module: spk_layer_engine
// PURPOSE
//  Parametrised spike-processing engine for one SNN layer: registered per-neuron Schmitt spike generation,
//  refractory timing and saturating spike counters, plus a chunked input-spike frame buffer.
//  Sits between the crossbar/potential readout and the next layer's spike-access bus.
// PARAMETERS
//  N_NEU      16    neurons processed in parallel
//  POT_W      8     signed membrane-potential width per neuron
//  TH_HI      8'sd64   spike threshold (pot >= TH_HI fires)
//  TH_LO      8'sd16   re-arm threshold (pot < TH_LO re-arms)
//  REFRAC     3     refractory length in pot_valid strobes (0 = none)
//  CNT_W      8     per-neuron spike counter width (saturating)
//  CHUNK_W    128   input spike chunk width
//  N_CHUNK    8     chunks per input frame (frame = CHUNK_W*N_CHUNK bits)
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-high
//  pot_in        in   N_NEU*POT_W        packed signed potentials, neuron j at [j*POT_W +: POT_W]
//  pot_valid     in   1                  strobe: evaluate pot_in this cycle
//  spk_out       out  N_NEU              registered spike vector, valid 1 cycle after pot_valid
//  spk_valid     out  1                  1-cycle pulse aligned with spk_out
//  armed_out     out  N_NEU              per-neuron spikability state
//  cnt_sel       in   $clog2(N_NEU)      counter read select
//  cnt_out       out  CNT_W              spike count of neuron cnt_sel (combinational mux)
//  cnt_clr       in   1                  clear all spike counters
//  in_chunk      in   CHUNK_W            input spike chunk
//  in_idx        in   $clog2(N_CHUNK)    destination chunk index
//  in_we         in   1                  chunk write enable
//  frame_out     out  CHUNK_W*N_CHUNK    input spike frame register
//  frame_valid   out  1                  all chunks written since last ack
//  frame_ack     in   1                  consumer took frame; clears load mask
//  ovw_err       out  1                  1-cycle pulse: chunk rewritten while frame_valid
// BEHAVIOUR
//  Reset: spk_out=0, spk_valid=0, armed_out=all 1, refractory counters=0, spike counters=0,
//   frame_out=0, load mask=0, frame_valid=0, ovw_err=0. Reset mid-operation discards all state.
//  Neuron path, per neuron j, evaluated only on a cycle with pot_valid=1 (pot signed compare):
//   - refractory cnt r>0: no spike, r<=r-1, armed unchanged.
//   - else armed && pot>=TH_HI: spike=1, armed<=0, r<=REFRAC, counter+1 (saturate at 2^CNT_W-1).
//   - else !armed && pot<TH_LO: armed<=1, no spike.
//   - else: no spike, state held.
//   spk_out/spk_valid registered; latency 1 cycle; spk_out held until next pot_valid, spk_valid 1 cycle.
//   Hysteresis band TH_LO<=pot<TH_HI never changes armed.
//   cnt_clr and a same-cycle spike: clear wins (counter=0).
//  Input frame path:
//   - in_we: frame_out[in_idx*CHUNK_W +: CHUNK_W] <= in_chunk; mask[in_idx] <= 1.
//   - frame_valid = &mask (registered, asserts cycle after last chunk write).
//   - frame_ack with frame_valid: mask<=0, frame_valid drops next cycle; frame_out data retained.
//   - frame_ack without frame_valid: ignored.
//   - in_we while frame_valid: data overwritten, ovw_err pulses 1 cycle, mask stays full.
//   - in_we and frame_ack same cycle: ack clears mask first, then the written bit is set (mask=one-hot).
//   - in_idx >= N_CHUNK (non-power-of-2 N_CHUNK): write ignored, no mask change.
//  Neuron and frame paths are independent; both may be active in the same cycle.
// TESTING
//  1 reset -> armed_out=16'hFFFF, spk_out=0, cnt_out=0 for all sel, frame_valid=0.
//  2 neuron0 pot=70 strobe -> spk_out[0]=1, spk_valid=1 next cycle; 3 further strobes pot=70 -> no spike (refractory);
//    then pot=70 -> no spike (not armed); pot=10 -> re-arm; pot=70 -> spike; cnt_out(sel0)=2.
//  3 pot oscillating 20<->60 (inside band) after spike -> never re-arms, no spikes.
//  4 300 spikes on neuron 5 with CNT_W=8 -> cnt_out saturates at 255; cnt_clr with coincident spike -> 0.
//  5 write chunks 0..7 (pattern idx*0x11 repeated) -> frame_valid=1 one cycle after chunk 7, frame_out matches;
//    write chunk 2 again -> ovw_err pulse; frame_ack -> frame_valid=0, frame_out retained.
//  6 frame_ack + in_we(idx 3) same cycle -> mask=8'b0000_1000, frame_valid=0; reset asserted mid-load -> mask=0, frame_out=0.

Source files
------------

// File: rtl/spk_layer_engine.sv
// Spike-processing engine for one SNN layer.
// Neuron path: per-neuron Schmitt spike generation with refractory timing and
// saturating spike counters, all evaluated only on pot_valid strobes.
// Frame path: chunked input-spike frame buffer with a load mask, a
// frame-complete flag, consumer acknowledge and overwrite detection.
// The two paths share no state and may both be active in the same cycle.
module spk_layer_engine #(
  parameter int                        N_NEU   = 16,
  parameter int                        POT_W   = 8,
  parameter logic signed [POT_W-1:0]   TH_HI   = 8'sd64,
  parameter logic signed [POT_W-1:0]   TH_LO   = 8'sd16,
  parameter int                        REFRAC  = 3,
  parameter int                        CNT_W   = 8,
  parameter int                        CHUNK_W = 128,
  parameter int                        N_CHUNK = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_NEU*POT_W-1:0]        pot_in,
  input  logic                          pot_valid,
  output logic [N_NEU-1:0]              spk_out,
  output logic                          spk_valid,
  output logic [N_NEU-1:0]              armed_out,
  input  logic [$clog2(N_NEU)-1:0]      cnt_sel,
  output logic [CNT_W-1:0]              cnt_out,
  input  logic                          cnt_clr,
  input  logic [CHUNK_W-1:0]            in_chunk,
  input  logic [$clog2(N_CHUNK)-1:0]    in_idx,
  input  logic                          in_we,
  output logic [CHUNK_W*N_CHUNK-1:0]    frame_out,
  output logic                          frame_valid,
  input  logic                          frame_ack,
  output logic                          ovw_err
);

  // Refractory counter must hold REFRAC; keep at least one bit when REFRAC is 0.
  localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int IDX_W = $clog2(N_CHUNK);

  logic [CNT_W-1:0] cnt_arr [N_NEU];
  logic             spk_valid_reg;

  // ---------------------------------------------------------------- neurons
  genvar gi;
  generate
    for (gi = 0; gi < N_NEU; gi++) begin : g_neu
      logic signed [POT_W-1:0] pot;
      logic [RW-1:0]           ref_reg;
      logic                    armed_reg;
      logic                    spk_reg;
      logic [CNT_W-1:0]        cnt_reg;
      logic                    fire;

      assign pot  = pot_in[gi*POT_W +: POT_W];
      // A spike needs a strobe, an expired refractory period and an armed neuron.
      assign fire = pot_valid && (ref_reg == '0) && armed_reg && (pot >= TH_HI);

      // Per-neuron state: refractory countdown, Schmitt arming, spike register, counter.
      always_ff @(posedge clk) begin
        if (reset) begin
          ref_reg   <= '0;
          armed_reg <= 1'b1;
          spk_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          if (pot_valid) begin
            spk_reg <= fire;
            if (ref_reg != '0) begin
              ref_reg <= ref_reg - RW'(1);
            end else if (fire) begin
              armed_reg <= 1'b0;
              ref_reg   <= RW'(REFRAC);
            end else if (!armed_reg && (pot < TH_LO)) begin
              armed_reg <= 1'b1;
            end
          end
          // Clear takes priority over a coincident spike.
          if (cnt_clr) begin
            cnt_reg <= '0;
          end else if (fire && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign spk_out[gi]   = spk_reg;
      assign armed_out[gi] = armed_reg;
      assign cnt_arr[gi]   = cnt_reg;
    end
  endgenerate

  // Spike-valid pulse follows each strobe by one cycle, aligned with spk_out.
  always_ff @(posedge clk) begin
    if (reset) spk_valid_reg <= 1'b0;
    else       spk_valid_reg <= pot_valid;
  end

  assign spk_valid = spk_valid_reg;
  assign cnt_out   = cnt_arr[cnt_sel];

  // ------------------------------------------------------------ input frame
  logic [N_CHUNK-1:0] mask_reg, mask_next;
  logic               frame_valid_reg;
  logic               ovw_reg;
  logic               we_ok;

  // Indices beyond the last chunk are dropped entirely.
  assign we_ok = in_we && (int'(in_idx) < N_CHUNK);

  // Load mask update: an accepted ack empties the mask before the new write lands.
  always_comb begin
    mask_next = mask_reg;
    if (frame_ack && frame_valid_reg) mask_next = '0;
    if (we_ok) mask_next[in_idx] = 1'b1;
  end

  // Mask, completion flag and overwrite pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg        <= '0;
      frame_valid_reg <= 1'b0;
      ovw_reg         <= 1'b0;
    end else begin
      mask_reg        <= mask_next;
      frame_valid_reg <= &mask_next;
      // A write into a completed, un-acknowledged frame corrupts it.
      ovw_reg         <= we_ok && frame_valid_reg && !frame_ack;
    end
  end

  generate
    for (gi = 0; gi < N_CHUNK; gi++) begin : g_chunk
      logic [CHUNK_W-1:0] chunk_reg;

      // Chunk storage; data is kept across acknowledges.
      always_ff @(posedge clk) begin
        if (reset)                                   chunk_reg <= '0;
        else if (we_ok && (in_idx == IDX_W'(gi)))   chunk_reg <= in_chunk;
      end

      assign frame_out[gi*CHUNK_W +: CHUNK_W] = chunk_reg;
    end
  endgenerate

  assign frame_valid = frame_valid_reg;
  assign ovw_err     = ovw_reg;

endmodule

// File: tb/tb_spk_layer_engine.sv
// Self-checking bench for spk_layer_engine: directed scenarios plus a
// randomized run, all compared against a rule-level reference model.
module tb_spk_layer_engine;
  localparam int N_NEU = 16, POT_W = 8, CNT_W = 8, CHUNK_W = 128, N_CHUNK = 8;
  localparam int TH_HI = 64, TH_LO = 16, REFRAC = 3, CNT_MAX = 255;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N_NEU*POT_W-1:0]      pot_in;
  logic                        pot_valid;
  logic [N_NEU-1:0]            spk_out;
  logic                        spk_valid;
  logic [N_NEU-1:0]            armed_out;
  logic [3:0]                  cnt_sel;
  logic [CNT_W-1:0]            cnt_out;
  logic                        cnt_clr;
  logic [CHUNK_W-1:0]          in_chunk;
  logic [2:0]                  in_idx;
  logic                        in_we;
  logic [CHUNK_W*N_CHUNK-1:0]  frame_out;
  logic                        frame_valid;
  logic                        frame_ack;
  logic                        ovw_err;

  always #5 clk = ~clk;

  spk_layer_engine dut (
    .clk(clk), .reset(reset), .pot_in(pot_in), .pot_valid(pot_valid),
    .spk_out(spk_out), .spk_valid(spk_valid), .armed_out(armed_out),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out), .cnt_clr(cnt_clr),
    .in_chunk(in_chunk), .in_idx(in_idx), .in_we(in_we),
    .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .ovw_err(ovw_err)
  );

  // Reference model state
  bit                 m_armed  [N_NEU];
  int                 m_ref    [N_NEU];
  int                 m_cnt    [N_NEU];
  bit                 m_spk    [N_NEU];
  bit                 m_spk_valid;
  logic [CHUNK_W-1:0] m_chunk  [N_CHUNK];
  bit                 m_loaded [N_CHUNK];
  bit                 m_fvalid;
  bit                 m_ovw;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic int pot_of(int j);
    logic signed [POT_W-1:0] p;
    p = pot_in[j*POT_W +: POT_W];
    return int'(p);
  endfunction

  function automatic logic [N_NEU-1:0] m_spk_vec();
    logic [N_NEU-1:0] v;
    for (int j = 0; j < N_NEU; j++) v[j] = m_spk[j];
    return v;
  endfunction

  function automatic logic [N_NEU-1:0] m_armed_vec();
    logic [N_NEU-1:0] v;
    for (int j = 0; j < N_NEU; j++) v[j] = m_armed[j];
    return v;
  endfunction

  function automatic logic [CHUNK_W*N_CHUNK-1:0] m_frame();
    logic [CHUNK_W*N_CHUNK-1:0] f;
    for (int c = 0; c < N_CHUNK; c++) f[c*CHUNK_W +: CHUNK_W] = m_chunk[c];
    return f;
  endfunction

  function automatic logic [CHUNK_W-1:0] pattern(int idx);
    logic [7:0] b;
    b = 8'(idx * 8'h11);
    return {16{b}};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N_NEU; j++) begin
      m_armed[j] = 1'b1; m_ref[j] = 0; m_cnt[j] = 0; m_spk[j] = 1'b0;
    end
    for (int c = 0; c < N_CHUNK; c++) begin
      m_chunk[c] = '0; m_loaded[c] = 1'b0;
    end
    m_spk_valid = 1'b0; m_fvalid = 1'b0; m_ovw = 1'b0;
  endtask

  task automatic idle();
    pot_valid = 0; cnt_clr = 0; in_we = 0; frame_ack = 0;
  endtask

  task automatic set_pot(int j, int v);
    pot_in[j*POT_W +: POT_W] = 8'(v);
  endtask

  // Advance the model by the current inputs, then clock the DUT once.
  task automatic tick();
    bit all;
    if (reset) begin
      model_reset();
    end else begin
      m_spk_valid = pot_valid;
      if (pot_valid) begin
        for (int j = 0; j < N_NEU; j++) begin
          int p;
          p = pot_of(j);
          m_spk[j] = 1'b0;
          if (m_ref[j] > 0) begin
            m_ref[j]--;
          end else if (m_armed[j] && p >= TH_HI) begin
            m_spk[j] = 1'b1; m_armed[j] = 1'b0; m_ref[j] = REFRAC;
            if (m_cnt[j] < CNT_MAX) m_cnt[j]++;
          end else if (!m_armed[j] && p < TH_LO) begin
            m_armed[j] = 1'b1;
          end
        end
      end
      if (cnt_clr) for (int j = 0; j < N_NEU; j++) m_cnt[j] = 0;
      m_ovw = in_we && m_fvalid && !frame_ack;
      if (frame_ack && m_fvalid) for (int c = 0; c < N_CHUNK; c++) m_loaded[c] = 1'b0;
      if (in_we) begin
        m_chunk[in_idx]  = in_chunk;
        m_loaded[in_idx] = 1'b1;
      end
      all = 1'b1;
      for (int c = 0; c < N_CHUNK; c++) all &= m_loaded[c];
      m_fvalid = all;
    end
    @(posedge clk); #1;
    cyc++;
    $display("cyc %0d rst=%0b pv=%0b clr=%0b we=%0b idx=%0d ack=%0b | spk=%h sv=%0b armed=%h cnt[%0d]=%0d fv=%0b ovw=%0b",
             cyc, reset, pot_valid, cnt_clr, in_we, in_idx, frame_ack,
             spk_out, spk_valid, armed_out, cnt_sel, cnt_out, frame_valid, ovw_err);
  endtask

  task automatic test_reset();
    idle(); pot_in = '0; cnt_sel = 0; in_chunk = '0; in_idx = 0;
    reset = 1; tick(); tick();
    reset = 0;
    n_cmp++; if (armed_out !== 16'hFFFF) begin n_bad++; $display("FAIL reset_armed: got %h want ffff", armed_out); end
    n_cmp++; if (spk_out !== 16'h0000) begin n_bad++; $display("FAIL reset_spk: got %h want 0000", spk_out); end
    n_cmp++; if (spk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_spk_valid: got %b want 0", spk_valid); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("FAIL reset_frame_out: nonzero frame"); end
    n_cmp++; if (ovw_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovw: got %b want 0", ovw_err); end
    for (int s = 0; s < N_NEU; s++) begin
      cnt_sel = 4'(s); #1;
      n_cmp++; if (cnt_out !== 8'd0) begin n_bad++; $display("FAIL reset_cnt sel %0d: got %0d want 0", s, cnt_out); end
    end
  endtask

  task automatic test_spike_basic();
    int pots [7];
    bit want [7];
    pots = '{70, 70, 70, 70, 70, 10, 70};
    want = '{1, 0, 0, 0, 0, 0, 1};
    pot_in = '0; cnt_sel = 0;
    for (int k = 0; k < 7; k++) begin
      idle(); pot_valid = 1; set_pot(0, pots[k]); tick();
      n_cmp++; if (spk_out[0] !== want[k] || spk_valid !== 1'b1)
        begin n_bad++; $display("FAIL spike_seq step %0d: spk0=%b sv=%b want spk0=%b sv=1", k, spk_out[0], spk_valid, want[k]); end
      if (k == 0) begin
        // spk_out holds across a non-strobe cycle, spk_valid does not
        idle(); tick();
        n_cmp++; if (spk_out[0] !== 1'b1 || spk_valid !== 1'b0)
          begin n_bad++; $display("FAIL spike_hold: spk0=%b sv=%b want 1/0", spk_out[0], spk_valid); end
        n_cmp++; if (armed_out[0] !== 1'b0) begin n_bad++; $display("FAIL disarm: got %b want 0", armed_out[0]); end
      end
    end
    idle(); tick();
    n_cmp++; if (cnt_out !== 8'd2) begin n_bad++; $display("FAIL spike_count: got %0d want 2", cnt_out); end
    n_cmp++; if (spk_out !== m_spk_vec() || armed_out !== m_armed_vec())
      begin n_bad++; $display("FAIL spike_model: spk=%h armed=%h want %h %h", spk_out, armed_out, m_spk_vec(), m_armed_vec()); end
  endtask

  task automatic test_hysteresis();
    pot_in = '0; cnt_sel = 1;
    idle(); pot_valid = 1; set_pot(1, 70); tick();
    n_cmp++; if (spk_out[1] !== 1'b1) begin n_bad++; $display("FAIL hyst_first_spike: got %b want 1", spk_out[1]); end
    for (int k = 0; k < 13; k++) begin
      idle(); pot_valid = 1; set_pot(1, (k % 2 == 0) ? 20 : 60); tick();
      n_cmp++; if (spk_out[1] !== 1'b0 || armed_out[1] !== 1'b0)
        begin n_bad++; $display("FAIL hyst_band step %0d: spk=%b armed=%b want 0/0", k, spk_out[1], armed_out[1]); end
    end
    // 63 is still inside the band: a disarmed neuron must not spike at TH_HI-1 or re-arm
    idle(); pot_valid = 1; set_pot(1, 63); tick();
    idle(); pot_valid = 1; set_pot(1, 16); tick();
    n_cmp++; if (armed_out[1] !== 1'b0) begin n_bad++; $display("FAIL hyst_edge16: armed=%b want 0", armed_out[1]); end
    idle(); pot_valid = 1; set_pot(1, 15); tick();
    n_cmp++; if (armed_out[1] !== 1'b1) begin n_bad++; $display("FAIL hyst_rearm15: armed=%b want 1", armed_out[1]); end
    idle(); pot_valid = 1; set_pot(1, 64); tick();
    n_cmp++; if (spk_out[1] !== 1'b1) begin n_bad++; $display("FAIL hyst_fire64: spk=%b want 1", spk_out[1]); end
    n_cmp++; if (cnt_out !== 8'(m_cnt[1])) begin n_bad++; $display("FAIL hyst_count: got %0d want %0d", cnt_out, m_cnt[1]); end
  endtask

  task automatic test_saturation();
    pot_in = '0; cnt_sel = 5;
    for (int k = 0; k < 300; k++) begin
      idle(); pot_valid = 1; set_pot(5, 70); tick();
      if (k == 253 || k == 254 || k == 299) begin
        n_cmp++; if (cnt_out !== 8'(m_cnt[5]) || m_cnt[5] != ((k + 1 > CNT_MAX) ? CNT_MAX : k + 1))
          begin n_bad++; $display("FAIL sat_count after %0d spikes: got %0d want %0d", k + 1, cnt_out, (k + 1 > CNT_MAX) ? CNT_MAX : k + 1); end
      end
      for (int r = 0; r < 4; r++) begin
        idle(); pot_valid = 1; set_pot(5, 0); tick();
      end
    end
    n_cmp++; if (cnt_out !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", cnt_out); end
    idle(); pot_valid = 1; set_pot(5, 70); cnt_clr = 1; tick();
    n_cmp++; if (cnt_out !== 8'd0 || spk_out[5] !== 1'b1)
      begin n_bad++; $display("FAIL clr_wins: cnt=%0d spk5=%b want 0/1", cnt_out, spk_out[5]); end
    idle(); tick();
  endtask

  task automatic test_frame();
    for (int c = 0; c < N_CHUNK; c++) begin
      idle(); in_we = 1; in_idx = 3'(c); in_chunk = pattern(c); tick();
      n_cmp++; if (frame_valid !== ((c == N_CHUNK - 1) ? 1'b1 : 1'b0))
        begin n_bad++; $display("FAIL frame_fill chunk %0d: fv=%b want %b", c, frame_valid, c == N_CHUNK - 1); end
    end
    n_cmp++; if (frame_out !== m_frame()) begin n_bad++; $display("FAIL frame_data: frame_out differs from written chunks"); end
    idle(); in_we = 1; in_idx = 2; in_chunk = {4{32'hDEADBEEF}}; tick();
    n_cmp++; if (ovw_err !== 1'b1 || frame_valid !== 1'b1)
      begin n_bad++; $display("FAIL ovw_pulse: ovw=%b fv=%b want 1/1", ovw_err, frame_valid); end
    idle(); tick();
    n_cmp++; if (ovw_err !== 1'b0) begin n_bad++; $display("FAIL ovw_one_cycle: got %b want 0", ovw_err); end
    n_cmp++; if (frame_out[2*CHUNK_W +: CHUNK_W] !== {4{32'hDEADBEEF}})
      begin n_bad++; $display("FAIL ovw_data: got %h", frame_out[2*CHUNK_W +: CHUNK_W]); end
    idle(); frame_ack = 1; tick();
    idle(); tick();
    n_cmp++; if (frame_valid !== 1'b0 || frame_out !== m_frame())
      begin n_bad++; $display("FAIL ack: fv=%b want 0, data retained=%b", frame_valid, frame_out === m_frame()); end
    // ack without a valid frame must change nothing
    idle(); frame_ack = 1; tick();
    n_cmp++; if (frame_valid !== 1'b0 || ovw_err !== 1'b0)
      begin n_bad++; $display("FAIL stray_ack: fv=%b ovw=%b want 0/0", frame_valid, ovw_err); end
    idle();
  endtask

  task automatic test_ack_write();
    int order [6];
    order = '{0, 1, 2, 4, 5, 6};
    for (int c = 0; c < N_CHUNK; c++) begin
      idle(); in_we = 1; in_idx = 3'(c); in_chunk = {4{$urandom}}; tick();
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL ackw_fill: fv=%b want 1", frame_valid); end
    idle(); frame_ack = 1; in_we = 1; in_idx = 3; in_chunk = {4{$urandom}}; tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ackw_same_cycle: fv=%b want 0", frame_valid); end
    for (int k = 0; k < 6; k++) begin
      idle(); in_we = 1; in_idx = 3'(order[k]); in_chunk = {4{$urandom}}; tick();
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ackw_partial idx %0d: fv=%b want 0", order[k], frame_valid); end
    end
    idle(); in_we = 1; in_idx = 7; in_chunk = {4{$urandom}}; tick();
    n_cmp++; if (frame_valid !== 1'b1 || frame_out !== m_frame())
      begin n_bad++; $display("FAIL ackw_complete: fv=%b want 1, data ok=%b", frame_valid, frame_out === m_frame()); end
    idle(); frame_ack = 1; tick();
    idle();
  endtask

  task automatic test_random();
    int lv [12];
    lv = '{-100, 0, 10, 15, 16, 17, 40, 63, 64, 65, 100, 127};
    for (int k = 0; k < 400; k++) begin
      idle();
      pot_valid = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N_NEU; j++) set_pot(j, lv[$urandom_range(0, 11)]);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      in_we     = ($urandom_range(0, 1) == 1);
      in_idx    = 3'($urandom_range(0, 7));
      in_chunk  = {$urandom, $urandom, $urandom, $urandom};
      frame_ack = ($urandom_range(0, 5) == 0);
      cnt_sel   = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (spk_out !== m_spk_vec() || spk_valid !== m_spk_valid || armed_out !== m_armed_vec() ||
          cnt_out !== 8'(m_cnt[cnt_sel]) || frame_valid !== m_fvalid || ovw_err !== m_ovw ||
          frame_out !== m_frame()) begin
        n_bad++;
        $display("FAIL random cyc %0d: spk=%h/%h sv=%b/%b armed=%h/%h cnt=%0d/%0d fv=%b/%b ovw=%b/%b frame_ok=%b",
                 cyc, spk_out, m_spk_vec(), spk_valid, m_spk_valid, armed_out, m_armed_vec(),
                 cnt_out, m_cnt[cnt_sel], frame_valid, m_fvalid, ovw_err, m_ovw, frame_out === m_frame());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    pot_in = '0;
    for (int c = 0; c < 4; c++) begin
      idle(); in_we = 1; in_idx = 3'(c); in_chunk = {4{$urandom | 32'h1}}; tick();
    end
    idle(); pot_valid = 1; set_pot(7, 100); tick();
    reset = 1; idle(); tick();
    reset = 0;
    n_cmp++; if (frame_out !== '0 || frame_valid !== 1'b0)
      begin n_bad++; $display("FAIL midreset_frame: fv=%b frame zero=%b want 0/1", frame_valid, frame_out === '0); end
    n_cmp++; if (armed_out !== 16'hFFFF || spk_out !== 16'h0 || spk_valid !== 1'b0)
      begin n_bad++; $display("FAIL midreset_neuron: armed=%h spk=%h sv=%b", armed_out, spk_out, spk_valid); end
    for (int c = 4; c < N_CHUNK; c++) begin
      idle(); in_we = 1; in_idx = 3'(c); in_chunk = pattern(c); tick();
    end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_mask: fv=%b want 0", frame_valid); end
    idle(); tick();
  endtask

  initial begin
    reset = 1;
    model_reset();
    test_reset();
    test_spike_basic();
    test_hysteresis();
    test_saturation();
    test_frame();
    test_ack_write();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
